// File: rtl/seq_game_pkg.sv
// -----------------------------------------------------------------------------
// seq_game_pkg
// Shared definitions for the sequence-memory game core:
//   - FSM state encodings (plain 3-bit constants so older tooling can read them)
//   - Galois LFSR feedback mask and single-step function
//   - onehot() helper that turns a button symbol into an LED/button pattern
// -----------------------------------------------------------------------------
package seq_game_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GEN      = 3'd1;
  localparam logic [2:0] ST_SHOW_ON  = 3'd2;
  localparam logic [2:0] ST_SHOW_OFF = 3'd3;
  localparam logic [2:0] ST_INPUT    = 3'd4;
  localparam logic [2:0] ST_WIN      = 3'd5;
  localparam logic [2:0] ST_LOSE     = 3'd6;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One step of the 16-bit Galois LFSR: shift right, apply mask when the
  // bit shifted out was 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Symbol (up to 4 bits) to a 16-bit one-hot pattern; callers truncate to
  // their button count.
  function automatic logic [15:0] onehot(input logic [3:0] sym);
    return 16'h0001 << sym;
  endfunction

endpackage

// File: rtl/seq_lfsr16.sv
// -----------------------------------------------------------------------------
// seq_lfsr16
// 16-bit Galois LFSR used as the symbol source of the game core.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, loads seed
//   en     in   advance one step on this edge
//   seed   in   16-bit load value (must be non-zero)
//   q      out  current LFSR state
// -----------------------------------------------------------------------------
module seq_lfsr16
  import seq_game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= seed;
    end else if (en) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign q = state_q;

endmodule

// File: rtl/seq_game_core.sv
// -----------------------------------------------------------------------------
// seq_game_core
// Simon-style sequence-memory game engine. Each level appends one random
// symbol, plays the whole sequence back on the LEDs, then waits for the player
// to repeat it on the buttons.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (priority over on)
//   on     in   power enable; 0 forces IDLE with all outputs 0
//   start  in   begins a new game from IDLE/WIN/LOSE
//   b      in   NBTN debounced button levels
//   l      out  NBTN LED drive (one-hot during playback, echo of b in INPUT,
//               all-ones in WIN)
//   level  out  current level, 0 in IDLE
//   busy   out  1 while generating/playing back
//   win    out  1 in WIN
//   lose   out  1 in LOSE
// -----------------------------------------------------------------------------
module seq_game_core
  import seq_game_pkg::*;
#(
  parameter int          NBTN      = 4,
  parameter int          MAX_LEVEL = 8,
  parameter int          SHOW_CYC  = 4,
  parameter int          GAP_CYC   = 2,
  parameter int          TIMEOUT   = 64,
  parameter logic [15:0] SEED      = 16'hACE1
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           on,
  input  logic                           start,
  input  logic [NBTN-1:0]                b,
  output logic [NBTN-1:0]                l,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level,
  output logic                           busy,
  output logic                           win,
  output logic                           lose
);

  localparam int IW   = $clog2(NBTN);
  localparam int LW   = $clog2(MAX_LEVEL+1);
  localparam int AW   = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int CMAX = (SHOW_CYC > GAP_CYC) ?
                        ((SHOW_CYC > TIMEOUT) ? SHOW_CYC : TIMEOUT) :
                        ((GAP_CYC > TIMEOUT) ? GAP_CYC : TIMEOUT);
  localparam int CW   = $clog2(CMAX+1);

  function automatic logic [NBTN-1:0] led_of(input logic [IW-1:0] s);
    return NBTN'(onehot(4'(s)));
  endfunction

  // Registers
  logic [2:0]      state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;        // shared show/gap/timeout down-counter
  logic [NBTN-1:0] l_q, l_d;
  logic [NBTN-1:0] b_q;
  logic            busy_q, win_q, lose_q;
  logic [IW-1:0]   seq_q [MAX_LEVEL];

  logic [15:0]     lfsr_q;
  logic            lfsr_en;
  logic [IW-1:0]   sym_new;
  logic            wr_en;
  logic [LW-1:0]   level_m1;
  logic            last;
  logic            press;
  logic [NBTN-1:0] exp_led;

  seq_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  // The stored symbol is taken from the LFSR value after this cycle's advance.
  assign lfsr_en  = on && (state_q == ST_GEN);
  assign sym_new  = IW'(lfsr_step(lfsr_q));
  assign level_m1 = level_q - LW'(1);
  assign last     = (LW'(idx_q) == level_m1);
  // A press is a rising edge out of the all-released state only.
  assign press    = (b_q == '0) && (b != '0);
  assign exp_led  = led_of(seq_q[idx_q]);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    l_d     = '0;
    wr_en   = 1'b0;
    if (!on) begin
      state_d = ST_IDLE;
      level_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_GEN;
            level_d = LW'(1);
          end
        end
        ST_GEN: begin
          wr_en   = 1'b1;
          idx_d   = '0;
          cnt_d   = CW'(SHOW_CYC-1);
          state_d = ST_SHOW_ON;
          // On level 1 the first symbol is the one being written right now.
          l_d     = led_of((level_m1 == '0) ? sym_new : seq_q[0]);
        end
        ST_SHOW_ON: begin
          if (cnt_q == '0) begin
            state_d = ST_SHOW_OFF;
            cnt_d   = CW'(GAP_CYC-1);
          end else begin
            cnt_d = cnt_q - CW'(1);
            l_d   = l_q;
          end
        end
        ST_SHOW_OFF: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (last) begin
            idx_d   = '0;
            cnt_d   = CW'(TIMEOUT-1);
            state_d = ST_INPUT;
            l_d     = b;
          end else begin
            idx_d   = idx_q + AW'(1);
            cnt_d   = CW'(SHOW_CYC-1);
            state_d = ST_SHOW_ON;
            l_d     = led_of(seq_q[idx_d]);
          end
        end
        ST_INPUT: begin
          l_d = b;
          if (press) begin
            if (b != exp_led) begin
              state_d = ST_LOSE;
              l_d     = '0;
            end else if (!last) begin
              idx_d = idx_q + AW'(1);
              cnt_d = CW'(TIMEOUT-1);
            end else if (level_q == LW'(MAX_LEVEL)) begin
              state_d = ST_WIN;
              l_d     = '1;
            end else begin
              level_d = level_q + LW'(1);
              state_d = ST_GEN;
              l_d     = '0;
            end
          end else if (cnt_q == '0) begin
            state_d = ST_LOSE;
            l_d     = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_WIN, ST_LOSE: begin
          if (start) begin
            state_d = ST_GEN;
            level_d = LW'(1);
          end else if (state_q == ST_WIN) begin
            l_d = '1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      b_q     <= b;
      busy_q  <= (state_d == ST_GEN) || (state_d == ST_SHOW_ON) ||
                 (state_d == ST_SHOW_OFF);
      win_q   <= (state_d == ST_WIN);
      lose_q  <= (state_d == ST_LOSE);
    end
  end

  // Sequence store has no reset; entries are always written before being read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      seq_q[AW'(level_m1)] <= sym_new;
    end
  end

  assign l     = l_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule

// File: tb/tb_seq_game_core.sv
// -----------------------------------------------------------------------------
// tb_seq_game_core
// Directed bench for seq_game_core with NBTN=4, MAX_LEVEL=2, SHOW_CYC=2,
// GAP_CYC=1, TIMEOUT=8. Symbols from seed ACE1 (hand-computed LFSR states
// after each advance): E270, 7138, 389C, 1C4E, 0E27, B313, ED89, C2C4, 6162
// -> symbols 0,0,0,2,3,3,1,0,2.
// -----------------------------------------------------------------------------
module tb_seq_game_core;

  logic       clk = 1'b0;
  logic       reset, on, start;
  logic [3:0] b;
  logic [3:0] l;
  logic [1:0] level;
  logic       busy, win, lose;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_game_core #(
    .NBTN(4), .MAX_LEVEL(2), .SHOW_CYC(2), .GAP_CYC(1), .TIMEOUT(8),
    .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .on(on), .start(start), .b(b),
    .l(l), .level(level), .busy(busy), .win(win), .lose(lose)
  );

  typedef struct packed {
    logic       on;
    logic       start;
    logic [3:0] b;
    logic [3:0] l;
    logic [1:0] level;
    logic       busy;
    logic       win;
    logic       lose;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic o, input logic s, input logic [3:0] bb,
                              input logic [3:0] el, input logic [1:0] elv,
                              input logic ebz, input logic ew, input logic els);
    vec_t v;
    v.on = o; v.start = s; v.b = bb;
    v.l = el; v.level = elv; v.busy = ebz; v.win = ew; v.lose = els;
    return v;
  endfunction

  // Drive inputs, take one clock edge, settle 1 time unit past it.
  task automatic step(input logic o, input logic s, input logic [3:0] bb);
    on = o; start = s; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] el, input logic [1:0] elv,
                       input logic ebz, input logic ew, input logic els);
    tests++;
    if ({l, level, busy, win, lose} !== {el, elv, ebz, ew, els}) begin
      failed++;
      $display("FAIL %s: got l=%b level=%0d busy=%b win=%b lose=%b, expected l=%b level=%0d busy=%b win=%b lose=%b",
               name, l, level, busy, win, lose, el, elv, ebz, ew, els);
    end else begin
      $display("ok   %s: l=%b level=%0d busy=%b win=%b lose=%b",
               name, l, level, busy, win, lose);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- table: full games, lose by bad press, timeout, boundary presses ----
    vecs.push_back(mk(1,1,4'h0, 4'h0,2'd1,1,0,0)); // 0 start -> GEN
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd1,1,0,0)); // SHOW_ON s0
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,1,0,0)); // gap
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,0)); // INPUT
    vecs.push_back(mk(1,0,4'h1, 4'h0,2'd2,1,0,0)); // 5 correct -> GEN lvl2
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd2,1,0,0)); // show s0
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd2,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd2,1,0,0)); // show s1
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd2,1,0,0)); // 10
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,0,0,0)); // INPUT
    vecs.push_back(mk(1,0,4'h1, 4'h1,2'd2,0,0,0)); // press s0, echo
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,0,0,0));
    vecs.push_back(mk(1,0,4'h1, 4'hF,2'd2,0,1,0)); // 15 press s1 -> WIN
    vecs.push_back(mk(1,0,4'h0, 4'hF,2'd2,0,1,0));
    vecs.push_back(mk(1,1,4'h0, 4'h0,2'd1,1,0,0)); // new game
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h1,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,1,0,0)); // 20
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,0));
    vecs.push_back(mk(1,0,4'h3, 4'h0,2'd1,0,0,1)); // multi-press -> LOSE
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,1));
    vecs.push_back(mk(1,1,4'h0, 4'h0,2'd1,1,0,0)); // new game, s=2
    vecs.push_back(mk(1,0,4'h0, 4'h4,2'd1,1,0,0)); // 25
    vecs.push_back(mk(1,0,4'h0, 4'h4,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,0)); // INPUT entered
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,0)); // 7 idle clocks
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,1)); // 8th edge -> LOSE
    vecs.push_back(mk(1,1,4'h0, 4'h0,2'd1,1,0,0)); // new game, s=3
    vecs.push_back(mk(1,0,4'h0, 4'h8,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h8,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,0)); // INPUT entered
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,0,4'h0, 4'h0,2'd1,0,0,0));
    vecs.push_back(mk(1,0,4'h8, 4'h0,2'd2,1,0,0)); // press on 7th edge
    vecs.push_back(mk(1,0,4'h0, 4'h8,2'd2,1,0,0)); // show s0=3
    vecs.push_back(mk(1,0,4'h0, 4'h8,2'd2,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h8,2'd2,1,0,0)); // show s1=3
    vecs.push_back(mk(1,0,4'h0, 4'h8,2'd2,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,1,0,0));
    vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,0,0,0)); // INPUT
    vecs.push_back(mk(1,0,4'h8, 4'h8,2'd2,0,0,0)); // correct s0
    vecs.push_back(mk(1,0,4'h4, 4'h4,2'd2,0,0,0)); // change w/o release: no press
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,0,4'h0, 4'h0,2'd2,0,0,0));
    vecs.push_back(mk(1,0,4'h8, 4'hF,2'd2,0,1,0)); // press on 8th edge wins

    // ---- reset ----
    reset = 1'b1; on = 1'b1; start = 1'b0; b = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset", 4'h0, 2'd0, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 4'h0);
    check("idle_after_reset", 4'h0, 2'd0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].on, vecs[i].start, vecs[i].b);
      check($sformatf("vec%0d", i), vecs[i].l, vecs[i].level,
            vecs[i].busy, vecs[i].win, vecs[i].lose);
    end

    // ---- on dropped mid-show, then button held across SHOW->INPUT ----
    step(1, 1, 4'h0); check("on_gen",        4'h0, 2'd1, 1, 0, 0);
    step(1, 0, 4'h0); check("on_show_s1",    4'h2, 2'd1, 1, 0, 0);
    step(0, 0, 4'h0); check("on_off",        4'h0, 2'd0, 0, 0, 0);
    step(1, 0, 4'h0); check("on_back_idle0", 4'h0, 2'd0, 0, 0, 0);
    step(1, 0, 4'h0); check("on_back_idle1", 4'h0, 2'd0, 0, 0, 0);
    step(1, 1, 4'h0); check("hold_gen",      4'h0, 2'd1, 1, 0, 0);
    step(1, 0, 4'h1); check("hold_show0",    4'h1, 2'd1, 1, 0, 0);
    step(1, 0, 4'h1); check("hold_show1",    4'h1, 2'd1, 1, 0, 0);
    step(1, 0, 4'h1); check("hold_gap",      4'h0, 2'd1, 1, 0, 0);
    step(1, 0, 4'h1); check("hold_input",    4'h1, 2'd1, 0, 0, 0);
    step(1, 0, 4'h1); check("hold_no_press", 4'h1, 2'd1, 0, 0, 0);
    step(1, 0, 4'h0); check("hold_release",  4'h0, 2'd1, 0, 0, 0);
    step(1, 0, 4'h1); check("hold_real_press", 4'h0, 2'd2, 1, 0, 0);

    // ---- reset mid-game reloads the seed ----
    reset = 1'b1;
    step(1, 1, 4'h0); check("midgame_reset", 4'h0, 2'd0, 0, 0, 0);
    reset = 1'b0;
    step(1, 1, 4'h0); check("reseed_gen",    4'h0, 2'd1, 1, 0, 0);
    step(1, 0, 4'h0); check("reseed_sym",    4'h1, 2'd1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
